// File: rtl/sub_pkg.sv
// Shared types and defaults for the pipelined carry-select subtractor.
// sub_s1_t is the stage-1 register layout at the default width.
package sub_pkg;

    localparam int SUB_WIDTH = 32;
    localparam int SUB_SPLIT = SUB_WIDTH / 2;

    typedef struct packed {
        logic [SUB_SPLIT-1:0]           lo;
        logic                           c_lo;
        logic [SUB_WIDTH-SUB_SPLIT-1:0] hi0;
        logic                           c0;
        logic [SUB_WIDTH-SUB_SPLIT-1:0] hi1;
        logic                           c1;
        logic                           sa;
        logic                           sb;
    } sub_s1_t;

endpackage

// File: rtl/csel_segment.sv
// One ripple segment of the carry-select datapath: sum = x + y + ci.
module csel_segment #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    assign {co, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipelined_sub.sv
// Two-stage carry-select subtractor, diff = a - b - bin, with valid/ready on both sides.
// Stage 1 computes the low segment and both high-segment candidates; stage 2 selects.
module pipelined_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int SPLIT = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int HW = WIDTH - SPLIT;

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("pipelined_sub: WIDTH must be even and >= 4");
    end

    // Same field layout as sub_s1_t, sized from this instance's parameters.
    typedef struct packed {
        logic [SPLIT-1:0] lo;
        logic             c_lo;
        logic [HW-1:0]    hi0;
        logic             c0;
        logic [HW-1:0]    hi1;
        logic             c1;
        logic             sa;
        logic             sb;
    } s1_t;

    s1_t              s1_d;
    s1_t              s1_q;
    logic             s1_valid;
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] nb;
    logic [SPLIT-1:0] lo_sum;
    logic             lo_co;
    logic [HW-1:0]    hi0_sum;
    logic             hi0_co;
    logic [HW-1:0]    hi1_sum;
    logic             hi1_co;
    logic [HW-1:0]    hi_sel;
    logic             c_sel;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;

    // Subtraction as a + ~b + ~bin; the high segment is evaluated for both carry-ins.
    assign nb = ~b;

    csel_segment #(.W(SPLIT)) u_lo (
        .x(a[SPLIT-1:0]), .y(nb[SPLIT-1:0]), .ci(~bin), .sum(lo_sum), .co(lo_co)
    );
    csel_segment #(.W(HW)) u_hi0 (
        .x(a[WIDTH-1:SPLIT]), .y(nb[WIDTH-1:SPLIT]), .ci(1'b0), .sum(hi0_sum), .co(hi0_co)
    );
    csel_segment #(.W(HW)) u_hi1 (
        .x(a[WIDTH-1:SPLIT]), .y(nb[WIDTH-1:SPLIT]), .ci(1'b1), .sum(hi1_sum), .co(hi1_co)
    );

    assign s1_d = '{lo: lo_sum, c_lo: lo_co, hi0: hi0_sum, c0: hi0_co,
                    hi1: hi1_sum, c1: hi1_co, sa: a[WIDTH-1], sb: b[WIDTH-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset too, so outputs read as zero and never X after reset.
            s1_q     <= '0;
            s1_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (accept) begin
                s1_q <= s1_d;
            end
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign hi_sel = s1_q.c_lo ? s1_q.hi1 : s1_q.hi0;
    assign c_sel  = s1_q.c_lo ? s1_q.c1  : s1_q.c0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                diff     <= {hi_sel, s1_q.lo};
                bout     <= ~c_sel;
                overflow <= (s1_q.sa != s1_q.sb) && (hi_sel[HW-1] != s1_q.sa);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_sub.sv
// Self-checking bench for pipelined_sub: directed vectors, back-pressure,
// random out_ready stream against a signed/unsigned reference model, and mid-stream reset.
module tb_pipelined_sub;

    localparam int W       = 32;
    localparam int TIMEOUT = 200;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    logic rand_ready = 1'b0;

    pipelined_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t        e;
        logic [W:0]  u;
        longint      s;
        u      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        s      = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
        e.diff = u[W-1:0];
        e.bout = u[W];
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return e;
    endfunction

    // Output monitor: a handshake decided at this negedge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("diff", 64'(diff), 64'(e.diff));
                check("bout", 64'(bout), 64'(e.bout));
                check("overflow", 64'(overflow), 64'(e.ovf));
                n_out++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        bit ok;
        ok = 1'b0;
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        for (int n = 0; n < TIMEOUT; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            check("accept_timeout", 64'd1, 64'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        q.push_back(model(ta, tb, tbin));
        #1;
        in_valid = 1'b0;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        for (int n = 0; n < TIMEOUT && q.size() != 0; n++) step();
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    logic [W-1:0] bp_a [6];
    logic [W-1:0] bp_b [6];
    logic [W-1:0] held;
    int           k;
    int           out0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_bout", 64'(bout), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Latency: accepted at the end of this cycle, out_valid two edges on
        send(32'h0000_0005, 32'h0000_0003, 1'b0);
        check("lat_edge1", 64'(out_valid), 64'd0);
        step();
        check("lat_edge2", 64'(out_valid), 64'd1);
        drain();

        // Directed vectors, back to back
        send(32'h8000_0000, 32'h0000_0001, 1'b0);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 1'b1);
        send(-32'sd999, -32'sd999, 1'b0);
        send(32'h0001_0000, 32'h0000_0001, 1'b0);
        send(32'h0001_0000, 32'h0000_FFFF, 1'b1);
        drain();

        // Back-pressure: six beats, out_ready low for cycles 3..5
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 32'h1000_0000 * (i + 1) + 32'h0000_1234;
            bp_b[i] = 32'h0000_0111 * (i + 1);
        end
        out0 = n_out;
        k    = 0;
        held = '0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = 1'b1;
            a = bp_a[k]; b = bp_b[k]; bin = 1'b0;
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_held_beats", 64'(q.size()), 64'd2);
                if (c == 3) held = diff;
                else check("bp_diff_stable", 64'(diff), 64'(held));
            end
            if (in_ready) begin
                @(posedge clk);
                q.push_back(model(bp_a[k], bp_b[k], 1'b0));
                k++;
                #1;
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("bp_beats_out", 64'(n_out - out0), 64'd6);

        // Random operands with random out_ready
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h0000_0001, 1'b0);
        send(32'h2222_2222, 32'h1111_1111, 1'b0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_diff", 64'(diff), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        send(32'h0000_0010, 32'h0000_0020, 1'b0);
        check("post_rst_edge1", 64'(out_valid), 64'd0);
        step();
        check("post_rst_edge2", 64'(out_valid), 64'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
